uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered UART transmitter. Words are written into a small FIFO and sent
//   as serial frames: start bit, DATA_BITS data bits (LSB first), an optional
//   parity bit and STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT cycles.
//   When a frame ends and another word is waiting (with en high), the next
//   start bit follows immediately with no idle bit in between.
//
// Ports
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   en         : allows new frames to start (a frame in flight always completes)
//   in_valid   : write request
//   in_data    : word to transmit (DATA_BITS wide)
//   in_ready   : FIFO not full
//   out        : serial tx line (idles high)
//   busy       : frame in progress
//   done       : one-cycle pulse after the last stop bit
//   fifo_count : FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        in_valid,
   input  logic [DATA_BITS-1:0]        in_data,
   output logic                        in_ready,
   output logic                        out,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [3:0]        LAST_DATA   = 4'(DATA_BITS - 1);
   localparam logic [3:0]        LAST_STOP   = 4'(STOP_BITS - 1);
   // Odd parity is the inverted XOR of the data bits.
   localparam logic              PAR_INV     = (PARITY == 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // Control registers
   state_t               r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [3:0]           r_bit;
   logic                 r_out;
   logic                 r_busy;
   logic                 r_done;
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;

   // Data registers
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;

   // Next-state / combinational signals
   state_t               w_state_nxt;
   logic [BAUD_W-1:0]    w_baud_nxt;
   logic [3:0]           w_bit_nxt;
   logic                 w_out_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_par_nxt;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_tick;
   logic                 w_can_start;
   logic [DATA_BITS-1:0] w_head;

   assign in_ready    = (r_count != FULL_COUNT);
   assign w_push      = in_valid & in_ready;
   assign w_tick      = (r_baud == '0);
   assign w_can_start = en & (r_count != '0);
   assign w_head      = r_mem[r_rd_ptr];

   assign out        = r_out;
   assign busy       = r_busy;
   assign done       = r_done;
   assign fifo_count = r_count;

   // Next-state and output logic. The baud counter counts down from
   // CLKS_PER_BIT-1; reaching zero marks the last cycle of the current bit.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_out_nxt   = r_out;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_par;
      w_pop       = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_can_start) begin
               w_pop = 1'b1;
            end
         end

         START: begin
            if (!w_tick) begin
               w_baud_nxt = r_baud - 1'b1;
            end else begin
               w_baud_nxt  = BAUD_RELOAD;
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
               w_out_nxt   = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end
         end

         DATA: begin
            if (!w_tick) begin
               w_baud_nxt = r_baud - 1'b1;
            end else begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_bit == LAST_DATA) begin
                  w_bit_nxt = '0;
                  if (PARITY != 0) begin
                     w_state_nxt = PAR;
                     w_out_nxt   = r_par;
                  end else begin
                     w_state_nxt = STOP;
                     w_out_nxt   = 1'b1;
                  end
               end else begin
                  w_bit_nxt   = r_bit + 1'b1;
                  w_out_nxt   = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
               end
            end
         end

         PAR: begin
            if (!w_tick) begin
               w_baud_nxt = r_baud - 1'b1;
            end else begin
               w_baud_nxt  = BAUD_RELOAD;
               w_state_nxt = STOP;
               w_bit_nxt   = '0;
               w_out_nxt   = 1'b1;
            end
         end

         STOP: begin
            if (!w_tick) begin
               w_baud_nxt = r_baud - 1'b1;
            end else if (r_bit != LAST_STOP) begin
               w_baud_nxt = BAUD_RELOAD;
               w_bit_nxt  = r_bit + 1'b1;
            end else begin
               w_done_nxt = 1'b1;
               if (w_can_start) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_baud_nxt  = '0;
                  w_bit_nxt   = '0;
                  w_out_nxt   = 1'b1;
                  w_busy_nxt  = 1'b0;
               end
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_out_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase

      // Frame launch, shared by IDLE and the back-to-back path out of STOP:
      // the head word and its parity are captured and the start bit begins.
      if (w_pop) begin
         w_state_nxt = START;
         w_baud_nxt  = BAUD_RELOAD;
         w_bit_nxt   = '0;
         w_out_nxt   = 1'b0;
         w_busy_nxt  = 1'b1;
         w_shift_nxt = w_head;
         w_par_nxt   = (^w_head) ^ PAR_INV;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_out    <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_out   <= w_out_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three transmitter configurations, all CLKS_PER_BIT=4, FIFO_DEPTH=4:
//     inst 0 : 8 data bits, no parity, 1 stop
//     inst 1 : 8 data bits, even parity, 1 stop
//     inst 2 : 7 data bits, odd parity, 2 stops
//   Stimulus queues the expected frame bit pattern (bit i = i-th bit on the
//   line) for every accepted word; a per-instance monitor reassembles frames
//   from the line and compares them with the queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int CPB = 4;

   typedef struct {
      int          id;
      logic [15:0] frm;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [2:0] en;
   logic [2:0] vld;
   logic [7:0] din     [3];
   logic       rdy_o   [3];
   logic       txo_o   [3];
   logic       bsy_o   [3];
   logic       dn_o    [3];
   logic [2:0] cnt_o   [3];

   exp_t exp_q[$];
   int   n_cmp;
   int   n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] frm);
      exp_t e;
      e.id  = id;
      e.frm = frm;
      exp_q.push_back(e);
   endtask

   task automatic push(input int g, input logic [7:0] d);
      @(negedge clk);
      vld[g] = 1'b1;
      din[g] = d;
      @(posedge clk);
      #1;
      vld[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g, input int max_cyc, input string nm);
      int n;
      n = 0;
      while (bsy_o[g] && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(nm, int'(bsy_o[g]), 0);
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int DB = (g == 2) ? 7 : 8;
      localparam int PB = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
      localparam int SB = (g == 2) ? 2 : 1;
      localparam int NB = 1 + DB + ((PB != 0) ? 1 : 0) + SB;
      localparam int NS = NB * CPB;

      uart_tx_fifo #(
         .DATA_BITS    (DB),
         .CLKS_PER_BIT (CPB),
         .PARITY       (PB),
         .STOP_BITS    (SB),
         .FIFO_DEPTH   (4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .en         (en[g]),
         .in_valid   (vld[g]),
         .in_data    (din[g][DB-1:0]),
         .in_ready   (rdy_o[g]),
         .out        (txo_o[g]),
         .busy       (bsy_o[g]),
         .done       (dn_o[g]),
         .fifo_count (cnt_o[g])
      );

      // Line monitor: samples every negedge, checks each bit is stable for
      // CPB samples with busy high, then expects done on the sample after
      // the frame's last cycle.
      initial begin : mon
         int          j;
         logic [15:0] rx;
         logic        shape_ok;
         logic        bv;
         logic        in_fr;
         logic        at_end;
         exp_t        e;
         j        = 0;
         rx       = '0;
         shape_ok = 1'b1;
         bv       = 1'b1;
         in_fr    = 1'b0;
         at_end   = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               in_fr  = 1'b0;
               at_end = 1'b0;
            end else begin
               if (at_end) begin
                  chk($sformatf("done_at_frame_end[%0d]", g), int'(dn_o[g]), 1);
                  at_end = 1'b0;
               end else if (dn_o[g]) begin
                  chk($sformatf("unexpected_done[%0d]", g), 1, 0);
               end
               if (!in_fr && !txo_o[g]) begin
                  in_fr    = 1'b1;
                  j        = 0;
                  rx       = '0;
                  shape_ok = 1'b1;
               end
               if (in_fr) begin
                  if (j % CPB == 0) begin
                     bv          = txo_o[g];
                     rx[j / CPB] = bv;
                  end else if (txo_o[g] != bv) begin
                     shape_ok = 1'b0;
                  end
                  if (!bsy_o[g]) shape_ok = 1'b0;
                  j++;
                  if (j == NS) begin
                     in_fr  = 1'b0;
                     at_end = 1'b1;
                     chk($sformatf("frame_shape[%0d]", g), int'(shape_ok), 1);
                     if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_frame[%0d]", g), int'(rx), -1);
                     end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("frame_inst[%0d]", g), g, e.id);
                        chk($sformatf("frame_bits[%0d]", g), int'(rx), int'(e.frm));
                     end
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int run;
      int dones;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      en    = 3'b000;
      vld   = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", int'(txo_o[0]), 1);
      chk("rst_busy", int'(bsy_o[0]), 0);
      chk("rst_done", int'(dn_o[0]), 0);
      chk("rst_count", int'(cnt_o[0]), 0);
      chk("rst_ready", int'(rdy_o[0]), 1);
      @(negedge clk);
      rst = 1'b0;

      // 8N1, 0xA5: start one edge after the push, 40-cycle frame
      en[0] = 1'b1;
      push_exp(0, {6'd0, 1'b1, 8'hA5, 1'b0});
      push(0, 8'hA5);
      chk("push_count", int'(cnt_o[0]), 1);
      chk("push_out_still_high", int'(txo_o[0]), 1);
      @(posedge clk);
      #1;
      chk("start_out_low", int'(txo_o[0]), 0);
      chk("start_busy", int'(bsy_o[0]), 1);
      chk("start_popped", int'(cnt_o[0]), 0);
      wait_idle(0, 100, "a5_timeout");

      // en=0: fill the FIFO, fifth push refused, line stays idle
      @(negedge clk);
      en[0] = 1'b0;
      push_exp(0, {6'd0, 1'b1, 8'h00, 1'b0});
      push_exp(0, {6'd0, 1'b1, 8'hFF, 1'b0});
      push_exp(0, {6'd0, 1'b1, 8'h3C, 1'b0});
      push_exp(0, {6'd0, 1'b1, 8'h81, 1'b0});
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h3C);
      push(0, 8'h81);
      chk("full_ready", int'(rdy_o[0]), 0);
      chk("full_count", int'(cnt_o[0]), 4);
      push(0, 8'h99);
      chk("refused_count", int'(cnt_o[0]), 4);
      repeat (8) @(negedge clk);
      chk("disabled_out", int'(txo_o[0]), 1);
      chk("disabled_busy", int'(bsy_o[0]), 0);

      // en=1: four back-to-back frames, busy unbroken for 4*40 cycles
      @(negedge clk);
      en[0] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bsy_o[0] && n < 8);
      chk("b2b_busy_rise", int'(bsy_o[0]), 1);
      run   = 0;
      dones = 0;
      while (n < 600) begin
         if (dn_o[0]) dones++;
         if (!bsy_o[0]) break;
         run++;
         @(negedge clk);
         n++;
      end
      chk("b2b_busy_cycles", run, 160);
      chk("b2b_done_pulses", dones, 4);
      chk("b2b_final_count", int'(cnt_o[0]), 0);

      // Reset during data bit 3 with a second word still queued
      push_exp(0, {6'd0, 1'b1, 8'hA5, 1'b0});
      push(0, 8'hA5);
      push_exp(0, {6'd0, 1'b1, 8'h5A, 1'b0});
      push(0, 8'h5A);
      chk("push_pop_same_edge_count", int'(cnt_o[0]), 1);
      chk("abort_frame_started", int'(txo_o[0]), 0);
      repeat (17) @(posedge clk);
      #2;
      exp_q.delete();
      rst = 1'b1;
      #1;
      chk("abort_out", int'(txo_o[0]), 1);
      chk("abort_busy", int'(bsy_o[0]), 0);
      chk("abort_count", int'(cnt_o[0]), 0);
      repeat (3) @(posedge clk);
      push_exp(0, {6'd0, 1'b1, 8'h3C, 1'b0});
      @(negedge clk);
      rst    = 1'b0;
      vld[0] = 1'b1;
      din[0] = 8'h3C;
      @(posedge clk);
      #1;
      vld[0] = 1'b0;
      chk("first_push_after_reset", int'(cnt_o[0]), 1);
      @(posedge clk);
      #1;
      chk("after_reset_start", int'(bsy_o[0]), 1);
      wait_idle(0, 100, "after_reset_timeout");

      // 8E1: 0x07 -> parity 1, 0x03 -> parity 0, 44-cycle frames
      @(negedge clk);
      en[1] = 1'b1;
      push_exp(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0});
      push(1, 8'h07);
      push_exp(1, {5'd0, 1'b1, 1'b0, 8'h03, 1'b0});
      push(1, 8'h03);
      chk("even_busy", int'(bsy_o[1]), 1);
      wait_idle(1, 200, "even_timeout");
      chk("even_final_count", int'(cnt_o[1]), 0);

      // 7O2: bit 7 of the bench's byte never reaches the 7-bit port
      @(negedge clk);
      en[2] = 1'b1;
      push_exp(2, {5'd0, 2'b11, 1'b0, 7'h07, 1'b0});
      push(2, 8'h87);
      push_exp(2, {5'd0, 2'b11, 1'b1, 7'h55, 1'b0});
      push(2, 8'hD5);
      chk("odd_busy", int'(bsy_o[2]), 1);
      wait_idle(2, 200, "odd_timeout");
      chk("odd_final_count", int'(cnt_o[2]), 0);

      repeat (3) @(negedge clk);
      chk("all_frames_seen", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
